// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer
//   Captures {pc, instr, timestamp} from a core into a small FIFO whenever the
//   PC changes while the capture FSM is in RUN. The FIFO either stops when
//   full (WRAP=0) or overwrites its oldest entry (WRAP=1). A capture of
//   ECALL/EBREAK halts tracing. TIMEOUT RUN cycles force a stop.
//
// Ports
//   clk, reset            : clock; asynchronous active-high reset
//   enable                : level-sensitive capture enable (IDLE <-> RUN)
//   pc_in, instr_in       : core PC / instruction being observed
//   rd_en                 : pop the oldest entry
//   rd_valid, rd_pc,
//   rd_instr, rd_cycle    : popped entry, one cycle after rd_en
//   count                 : entries currently held
//   cycle_count           : cycles spent in RUN (saturating)
//   overflow              : sticky, an entry was lost or overwritten
//   halted, timed_out     : high while in the HALT / TMO terminal states
module exec_trace_buffer #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16,
    parameter int TIMEOUT = 1000,
    parameter int WRAP    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [XLEN-1:0]          instr_in,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
    output logic [CYCLE_W-1:0]       rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CYCLE_W-1:0]       cycle_count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     timed_out
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0]      ptr_t;
    typedef logic [AW:0]        cnt_t;
    typedef logic [CYCLE_W-1:0] cyc_t;
    typedef logic [XLEN-1:0]    word_t;

    localparam cnt_t  FULL_CNT = cnt_t'(DEPTH);
    localparam bit    WRAP_EN  = (WRAP != 0);
    localparam bit    TMO_EN   = (TIMEOUT != 0);
    localparam cyc_t  TMO_LAST = cyc_t'(TMO_EN ? TIMEOUT - 1 : 0);
    localparam word_t ECALL    = word_t'(32'h0000_0073);
    localparam word_t EBREAK   = word_t'(32'h0010_0073);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_TMO} state_t;

    state_t state_q;
    cyc_t   cycle_q;
    logic   halted_q, tmo_q, first_q, ovf_q;
    word_t  prev_pc_q;
    ptr_t   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    cnt_t   count_q, count_d;
    logic   rd_valid_q;
    word_t  rd_pc_q, rd_instr_q;
    cyc_t   rd_cycle_q;

    word_t  pc_mem    [DEPTH];
    word_t  instr_mem [DEPTH];
    cyc_t   cyc_mem   [DEPTH];

    logic run, cap, full, pop, wr, drop, ovw, is_halt, is_tmo;

    always_comb begin
        run     = (state_q == S_RUN);
        cap     = run && enable && (first_q || (pc_in != prev_pc_q));
        full    = (count_q == FULL_CNT);
        pop     = rd_en && (count_q != '0);
        // A full buffer still accepts a capture if the same cycle frees a slot
        // or if it is allowed to overwrite the oldest entry.
        wr      = cap && (!full || pop || WRAP_EN);
        drop    = cap && full && !pop && !WRAP_EN;
        ovw     = cap && full && !pop && WRAP_EN;
        is_halt = cap && ((instr_in == ECALL) || (instr_in == EBREAK));
        is_tmo  = run && TMO_EN && (cycle_q == TMO_LAST);

        wr_ptr_d = wr         ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = (pop || ovw) ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr && !pop && !ovw) count_d = count_q + cnt_t'(1);
        else if (pop && !wr)    count_d = count_q - cnt_t'(1);
    end

    // Capture FSM; halt takes priority over timeout, both over enable drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            halted_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (run && (cycle_q != '1)) cycle_q <= cycle_q + cyc_t'(1);
            case (state_q)
                S_IDLE: if (enable) state_q <= S_RUN;
                S_RUN: begin
                    if (is_halt) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (is_tmo) begin
                        state_q <= S_TMO;
                        tmo_q   <= 1'b1;
                    end else if (!enable) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    // FIFO control and read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b1;
            prev_pc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
            rd_cycle_q <= '0;
        end else begin
            if (cap) begin
                first_q   <= 1'b0;
                prev_pc_q <= pc_in;
            end
            if (drop || ovw) ovf_q <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= pop;
            // Read uses the pre-write array, so capture+pop on the same slot
            // returns the old entry.
            if (pop) begin
                rd_pc_q    <= pc_mem[rd_ptr_q];
                rd_instr_q <= instr_mem[rd_ptr_q];
                rd_cycle_q <= cyc_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wr_ptr_q]    <= pc_in;
            instr_mem[wr_ptr_q] <= instr_in;
            cyc_mem[wr_ptr_q]   <= cycle_q;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_pc       = rd_pc_q;
    assign rd_instr    = rd_instr_q;
    assign rd_cycle    = rd_cycle_q;
    assign count       = count_q;
    assign cycle_count = cycle_q;
    assign overflow    = ovf_q;
    assign halted      = halted_q;
    assign timed_out   = tmo_q;

endmodule
